// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int unsigned DEF_WIDTH = 9;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    CALC = S_CALC,
    FIX  = S_FIX,
    DONE = S_DONE
  } state_t;

  // Magnitude of the low 'width' bits of value; the most negative signed value maps to 2^(width-1).
  function automatic logic [31:0] abs_w(input logic [31:0] value, input int unsigned width,
                                        input logic signed_mode);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    if (signed_mode && value[width-1])
      return (~value + 32'd1) & mask;
    return value & mask;
  endfunction

endpackage

// File: rtl/seq_mult_hs_cond_negate.sv
// Combinational conditional two's-complement negation.
module cond_negate
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in;
    if (neg)
      out = ~in + WIDTH'(1);
  end

endmodule

// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier with run-time signed mode and valid/ready handshakes.
// Build option: SEQ_MULT_EARLY_TERM_EN ends CALC once the remaining multiplier bits are zero.
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  state_t           state;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_fixed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             calc_last;

  cond_negate #(.WIDTH(WIDTH)) u_abs_a (
    .neg (signed_mode & a[WIDTH-1]),
    .in  (a),
    .out (a_mag)
  );

  cond_negate #(.WIDTH(WIDTH)) u_abs_b (
    .neg (signed_mode & b[WIDTH-1]),
    .in  (b),
    .out (b_mag)
  );

  cond_negate #(.WIDTH(PW)) u_fix (
    .neg (neg),
    .in  (acc),
    .out (acc_fixed)
  );

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Bits above the one being processed are all zero: nothing left to add.
  always_comb calc_last = (mb[WIDTH-1:1] == '0);
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  always_comb calc_last = (cnt == LAST);
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state == CALC) || (state == FIX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      ma        <= '0;
      mb        <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            ma    <= a_mag;
            mb    <= b_mag;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (mb[0])
            acc <= acc + (PW'(ma) << cnt);
          mb  <= mb >> 1;
          cnt <= cnt + CNT_W'(1);
          if (calc_last)
            state <= FIX;
        end
        FIX: begin
          p         <= acc_fixed;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Self-checking bench for seq_mult_hs (WIDTH=9) against an arithmetic reference model.
module tb_seq_mult_hs;

  localparam int unsigned W = 9;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] p;
  logic           busy;

  int checks = 0;
  int errors = 0;

  seq_mult_hs #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint as_int(input logic [W-1:0] v, input logic sm);
    longint r;
    r = longint'(v);
    if (sm && v[W-1])
      r = r - (longint'(1) << W);
    return r;
  endfunction

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
    longint prod;
    logic [63:0] bits;
    prod = as_int(x, sm) * as_int(y, sm);
    bits = prod;
    return bits[2*W-1:0];
  endfunction

  function automatic int ref_latency(input logic [W-1:0] y, input logic sm);
`ifdef SEQ_MULT_EARLY_TERM_EN
    longint mag;
    int top;
    mag = as_int(y, sm);
    if (mag < 0) mag = -mag;
    top = 0;
    for (int i = 0; i < 64; i++)
      if (mag >= (longint'(1) << i)) top = i;
    return top + 2;
`else
    return W + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, time the result, hold under backpressure, drain.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tsm, input int hold, input logic poke);
    logic [2*W-1:0] exp_p;
    int n;
    exp_p = ref_prod(ta, tb, tsm);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; a = ta; b = tb; signed_mode = tsm; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    chk({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, ref_latency(tb, tsm));
    chk({tag, "_p"}, p, exp_p);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        in_valid = 1'b1; a = 9'd7; b = 9'd7; signed_mode = 1'b0;
      end
      tick();
      chk({tag, "_hold_p"}, p, exp_p);
      chk({tag, "_hold_v"}, out_valid, 1'b1);
      chk({tag, "_hold_rdy"}, in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain_v"}, out_valid, 1'b0);
    chk({tag, "_drain_rdy"}, in_ready, 1'b1);
    chk({tag, "_drain_busy"}, busy, 1'b0);
  endtask

  initial begin
    tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_p", p, '0);
    rst = 1'b0;
    tick();
    chk("rst_ready", in_ready, 1'b1);

    do_op("umax", 9'd511, 9'd511, 1'b0, 0, 1'b0);
    chk("umax_const", ref_prod(9'd511, 9'd511, 1'b0), 18'h3FC01);
    do_op("smin", 9'h100, 9'h100, 1'b1, 1, 1'b0);
    do_op("sneg1", 9'h1FF, 9'h001, 1'b1, 0, 1'b0);
    do_op("bp", 9'd3, 9'd5, 1'b0, 5, 1'b1);
    do_op("after_bp", 9'd11, 9'd13, 1'b0, 0, 1'b0);

    // Reset four cycles into CALC.
    in_valid = 1'b1; a = 9'd100; b = 9'd200; signed_mode = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_p", p, '0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_ready", in_ready, 1'b1);
    do_op("postrst", 9'd2, 9'd3, 1'b0, 0, 1'b0);

    do_op("zero_a", 9'd0, 9'h1AB, 1'b1, 0, 1'b0);
    do_op("zero_b", 9'h1AB, 9'd0, 1'b0, 0, 1'b0);
    do_op("small", 9'd7, 9'd3, 1'b0, 0, 1'b0);

    for (int i = 0; i < 24; i++)
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
